rdmx_recv_be: RTL and testbench
===============================

# rdmx_recv_be

Receive-side back end of the RDMX path. It consumes the three per-packet streams: a packet length, a user-data/target-address word, and the packet data beats. It turns each packet into one AXI4 INCR write burst on a master interface, with byte-exact strobes on the final beat. It tracks outstanding write responses, limits bursts in flight, and reports packet, response-error and length-error status.

## Interface
- DW, 512: data width in bits; byte lanes BPB = DW/8.
- AW, 64: AXI address width.
- UW, 32: user-data width carried in AWUSER.
- MAX_OUT, 8: maximum write bursts awaiting B response (1..255).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- AXIS_PLEN_TDATA  in  16  packet length in bytes.
- AXIS_PLEN_TVALID  in  1;  AXIS_PLEN_TREADY  out  1.
- AXIS_ADDR_TDATA  in  UW+AW  {user, address}; address in low AW bits.
- AXIS_ADDR_TVALID  in  1;  AXIS_ADDR_TREADY  out  1.
- AXIS_DATA_TDATA  in  DW;  AXIS_DATA_TLAST  in  1;  AXIS_DATA_TVALID  in  1;  AXIS_DATA_TREADY  out  1.
- M_AXI_AWADDR  out  AW;  M_AXI_AWUSER  out  UW;  M_AXI_AWLEN  out  8;  M_AXI_AWSIZE  out  3 (log2 BPB);  M_AXI_AWBURST  out  2 (01 INCR);  M_AXI_AWID  out  4 (0).
- M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  DW;  M_AXI_WSTRB  out  DW/8;  M_AXI_WLAST  out  1;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1.
- PKT_COUNT  out  32  number of OKAY B responses received.
- BRESP_ERR  out  1  sticky: a B response other than OKAY was seen.
- LEN_ERR  out  1  sticky: packet length or TLAST inconsistency.

## Operation
- FSM states: S_IDLE, S_AW, S_W.
- S_IDLE: AXIS_PLEN_TREADY = AXIS_ADDR_TREADY = PLEN_TVALID & ADDR_TVALID & (outstanding < MAX_OUT). Both streams pop together, never singly.
  - On the pop, latch addr, user and plen, compute the burst, and go to S_AW.
- Burst arithmetic:
  - beats = ceil(plen/BPB); plen = 0 counts as 1 beat.
  - AWLEN = (beats-1)[7:0].
  - LEN_ERR is set if plen = 0 or beats > 256.
- S_AW: AWVALID = 1, held with stable fields until AWREADY. On the handshake, increment outstanding, clear beat counter, go to S_W.
- S_W: W is driven through from the data stream.
  - WVALID = DATA_TVALID; DATA_TREADY = WREADY; WDATA = DATA_TDATA.
  - WLAST = (beat_cnt == AWLEN).
  - WSTRB is all ones, except on the WLAST beat: rem = plen mod BPB; rem = 0 gives all ones, otherwise (1<<rem)-1. For plen = 0 the WLAST strobe is all zeros.
  - On each W handshake, beat_cnt increments.
  - On a W handshake where DATA_TLAST != WLAST, set LEN_ERR. No padding or draining; the burst ends on the computed WLAST.
  - On the WLAST handshake, go to S_IDLE.
- DATA_TREADY = 0 outside S_W.
- B channel:
  - BREADY = 1 whenever not in reset.
  - Each B handshake decrements outstanding; PKT_COUNT increments if BRESP = 00, otherwise BRESP_ERR is set.
  - AW and B handshakes in the same cycle leave outstanding unchanged.
  - A B handshake with outstanding = 0 is ignored and does not underflow.
- PKT_COUNT wraps modulo 2^32.
- Sticky flags clear only on reset.

## Timing
- Reset (synchronous, one edge):
  - State returns to S_IDLE.
  - AWVALID, WVALID, all TREADYs and BREADY are 0 while reset is high.
  - outstanding, beat_cnt, PKT_COUNT, BRESP_ERR and LEN_ERR are all 0.
- Reset mid-burst abandons the burst immediately: no further W beats, outstanding cleared.
- AW fields and AWVALID are registered outputs.
- Latency:
  - Pop in cycle N gives AWVALID = 1 in N+1.
  - AW handshake in cycle M allows the first W beat in M+1.
  - WLAST handshake in cycle K allows the next pop in K+1 at the earliest.
- W is combinationally pass-through: zero-cycle latency, no buffering.
- Throughput for back-to-back packets with full readiness is beats+2 cycles per packet.
- With outstanding = MAX_OUT, the block stalls in S_IDLE. A B handshake in cycle K allows a pop in K+1.

## Test plan
- plen = 64, addr = 0x1000, user = 0xA5: one AW (AWLEN = 0, AWSIZE = 6, AWUSER = 0xA5), one W beat with WSTRB all ones and WLAST = 1; OKAY B → PKT_COUNT = 1.
- plen = 130: AWLEN = 2; beats 0-1 WSTRB all ones, beat 2 WSTRB = 0x3 with WLAST; LEN_ERR stays 0.
- MAX_OUT = 2 with BVALID withheld, 3 packets queued: exactly 2 AW handshakes, the third pop is stalled; one OKAY B → third AW one cycle later.
- Random WREADY/AWREADY backpressure over 20 packets: data order preserved, WDATA equals input, AW fields stable while AWVALID is high, PKT_COUNT = 20.
- plen = 128 with DATA_TLAST on beat 0, and separately plen = 0: LEN_ERR = 1 in both; BRESP = 10 → BRESP_ERR = 1 and PKT_COUNT not incremented.
- Reset asserted during beat 1 of a 4-beat burst: next cycle WVALID = 0, AWVALID = 0, counters 0; a following packet completes normally.

Source files
------------

// File: rtl/rdmx_recv_be.sv
// ---------------------------------------------------------------------------
// rdmx_recv_be -- receive-side back end of the RDMX path.
//
// Turns each packet (length + {user,address} + data beats) into one AXI4 INCR
// write burst. The final beat carries byte-exact strobes. The block tracks
// write responses that are still outstanding and limits bursts in flight.
// It also reports packet, response-error and length-error status.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   AXIS_PLEN_*         : packet length stream (bytes)
//   AXIS_ADDR_*         : {user, address} stream, address in low AW bits
//   AXIS_DATA_*         : packet data beats with TLAST
//   M_AXI_AW*           : write address channel (registered)
//   M_AXI_W*            : write data channel (pass-through from AXIS_DATA)
//   M_AXI_B*            : write response channel
//   PKT_COUNT           : number of OKAY responses (wraps)
//   BRESP_ERR, LEN_ERR  : sticky error flags, cleared only by reset
//
// DW must be at least 16 so that a beat has more than one byte lane.
// ---------------------------------------------------------------------------
module rdmx_recv_be #(
    parameter int DW      = 512,
    parameter int AW      = 64,
    parameter int UW      = 32,
    parameter int MAX_OUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      AXIS_PLEN_TDATA,
    input  logic             AXIS_PLEN_TVALID,
    output logic             AXIS_PLEN_TREADY,
    input  logic [UW+AW-1:0] AXIS_ADDR_TDATA,
    input  logic             AXIS_ADDR_TVALID,
    output logic             AXIS_ADDR_TREADY,
    input  logic [DW-1:0]    AXIS_DATA_TDATA,
    input  logic             AXIS_DATA_TLAST,
    input  logic             AXIS_DATA_TVALID,
    output logic             AXIS_DATA_TREADY,
    output logic [AW-1:0]    M_AXI_AWADDR,
    output logic [UW-1:0]    M_AXI_AWUSER,
    output logic [7:0]       M_AXI_AWLEN,
    output logic [2:0]       M_AXI_AWSIZE,
    output logic [1:0]       M_AXI_AWBURST,
    output logic [3:0]       M_AXI_AWID,
    output logic             M_AXI_AWVALID,
    input  logic             M_AXI_AWREADY,
    output logic [DW-1:0]    M_AXI_WDATA,
    output logic [DW/8-1:0]  M_AXI_WSTRB,
    output logic             M_AXI_WLAST,
    output logic             M_AXI_WVALID,
    input  logic             M_AXI_WREADY,
    input  logic [1:0]       M_AXI_BRESP,
    input  logic             M_AXI_BVALID,
    output logic             M_AXI_BREADY,
    output logic [31:0]      PKT_COUNT,
    output logic             BRESP_ERR,
    output logic             LEN_ERR
);

    localparam int         BPB       = DW / 8;
    localparam int         SZ        = $clog2(BPB);
    localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2
    } state_t;

    // Number of beats for a packet; a zero-length packet still moves one beat.
    function automatic logic [16:0] burst_beats(input logic [15:0] plen);
        logic [16:0] sum;
        sum = {1'b0, plen} + 17'(BPB - 1);
        if (plen == 16'd0) begin
            return 17'd1;
        end else begin
            return sum >> SZ;
        end
    endfunction

    // Strobe for the final beat: only the residual bytes, or none for plen = 0.
    function automatic logic [BPB-1:0] last_strobe(input logic [15:0] plen);
        logic [SZ-1:0]  rem;
        logic [BPB-1:0] strb;
        rem = plen[SZ-1:0];
        if (plen == 16'd0) begin
            strb = {BPB{1'b0}};
        end else if (rem == {SZ{1'b0}}) begin
            strb = {BPB{1'b1}};
        end else begin
            for (int i = 0; i < BPB; i++) begin
                strb[i] = (i < int'(rem));
            end
        end
        return strb;
    endfunction

    state_t          state_q;
    logic [AW-1:0]   awaddr_q;
    logic [UW-1:0]   awuser_q;
    logic [7:0]      awlen_q;
    logic            awvalid_q;
    logic [BPB-1:0]  last_strb_q;
    logic [7:0]      beat_cnt_q;
    logic [7:0]      out_q;
    logic [31:0]     pkt_count_q;
    logic            bresp_err_q;
    logic            len_err_q;

    logic [16:0]     beats_d;
    logic [7:0]      awlen_d;
    logic            plen_bad_d;
    logic [BPB-1:0]  last_strb_d;
    logic [7:0]      out_d;

    logic            pop_s;
    logic            aw_hs_s;
    logic            w_hs_s;
    logic            wlast_s;
    logic            b_acc_s;

    // Burst geometry of the packet at the head of the length stream.
    always_comb begin
        beats_d     = burst_beats(AXIS_PLEN_TDATA);
        awlen_d     = beats_d[7:0] - 8'd1;
        plen_bad_d  = (AXIS_PLEN_TDATA == 16'd0) || (beats_d > 17'd256);
        last_strb_d = last_strobe(AXIS_PLEN_TDATA);
    end

    // Both control streams pop together, only when a burst slot is free.
    assign pop_s   = (state_q == S_IDLE) && AXIS_PLEN_TVALID && AXIS_ADDR_TVALID
                     && (out_q < MAX_OUT_C) && !reset;
    assign aw_hs_s = M_AXI_AWVALID && M_AXI_AWREADY;
    assign wlast_s = (beat_cnt_q == awlen_q);
    assign w_hs_s  = (state_q == S_W) && AXIS_DATA_TVALID && M_AXI_WREADY && !reset;
    // A response with nothing outstanding is dropped entirely.
    assign b_acc_s = M_AXI_BVALID && !reset && (out_q != 8'd0);

    // Outstanding-burst count: simultaneous AW and B cancel out.
    always_comb begin
        out_d = out_q;
        if (aw_hs_s && !b_acc_s) begin
            out_d = out_q + 8'd1;
        end else if (b_acc_s && !aw_hs_s) begin
            out_d = out_q - 8'd1;
        end else begin
            out_d = out_q;
        end
    end

    // Control FSM, AW registers, beat counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            awaddr_q    <= {AW{1'b0}};
            awuser_q    <= {UW{1'b0}};
            awlen_q     <= 8'd0;
            awvalid_q   <= 1'b0;
            last_strb_q <= {BPB{1'b0}};
            beat_cnt_q  <= 8'd0;
            out_q       <= 8'd0;
            pkt_count_q <= 32'd0;
            bresp_err_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        awaddr_q    <= AXIS_ADDR_TDATA[AW-1:0];
                        awuser_q    <= AXIS_ADDR_TDATA[UW+AW-1:AW];
                        awlen_q     <= awlen_d;
                        last_strb_q <= last_strb_d;
                        awvalid_q   <= 1'b1;
                        state_q     <= S_AW;
                        if (plen_bad_d) begin
                            len_err_q <= 1'b1;
                        end
                    end
                end
                S_AW: begin
                    if (aw_hs_s) begin
                        awvalid_q  <= 1'b0;
                        beat_cnt_q <= 8'd0;
                        state_q    <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs_s) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        // The burst always ends on the computed WLAST; a TLAST
                        // disagreement is only flagged.
                        if (AXIS_DATA_TLAST != wlast_s) begin
                            len_err_q <= 1'b1;
                        end
                        if (wlast_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    awvalid_q <= 1'b0;
                end
            endcase

            out_q <= out_d;
            if (b_acc_s) begin
                if (M_AXI_BRESP == 2'b00) begin
                    pkt_count_q <= pkt_count_q + 32'd1;
                end else begin
                    bresp_err_q <= 1'b1;
                end
            end
        end
    end

    assign AXIS_PLEN_TREADY = pop_s;
    assign AXIS_ADDR_TREADY = pop_s;
    assign AXIS_DATA_TREADY = (state_q == S_W) && M_AXI_WREADY && !reset;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWUSER  = awuser_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = 3'(SZ);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWID    = 4'd0;
    assign M_AXI_AWVALID = awvalid_q && !reset;

    assign M_AXI_WDATA  = AXIS_DATA_TDATA;
    assign M_AXI_WVALID = (state_q == S_W) && AXIS_DATA_TVALID && !reset;
    assign M_AXI_WLAST  = (state_q == S_W) && wlast_s;
    assign M_AXI_WSTRB  = wlast_s ? last_strb_q : {BPB{1'b1}};

    assign M_AXI_BREADY = !reset;

    assign PKT_COUNT = pkt_count_q;
    assign BRESP_ERR = bresp_err_q;
    assign LEN_ERR   = len_err_q;

endmodule

// File: tb/tb_rdmx_recv_be.sv
module tb_rdmx_recv_be;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   AXIS_PLEN_TDATA;
    logic          AXIS_PLEN_TVALID;
    logic          AXIS_PLEN_TREADY;
    logic [95:0]   AXIS_ADDR_TDATA;
    logic          AXIS_ADDR_TVALID;
    logic          AXIS_ADDR_TREADY;
    logic [511:0]  AXIS_DATA_TDATA;
    logic          AXIS_DATA_TLAST;
    logic          AXIS_DATA_TVALID;
    logic          AXIS_DATA_TREADY;
    logic [63:0]   M_AXI_AWADDR;
    logic [31:0]   M_AXI_AWUSER;
    logic [7:0]    M_AXI_AWLEN;
    logic [2:0]    M_AXI_AWSIZE;
    logic [1:0]    M_AXI_AWBURST;
    logic [3:0]    M_AXI_AWID;
    logic          M_AXI_AWVALID;
    logic          M_AXI_AWREADY;
    logic [511:0]  M_AXI_WDATA;
    logic [63:0]   M_AXI_WSTRB;
    logic          M_AXI_WLAST;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID;
    logic          M_AXI_BREADY;
    logic [31:0]   PKT_COUNT;
    logic          BRESP_ERR;
    logic          LEN_ERR;

    rdmx_recv_be #(.DW(512), .AW(64), .UW(32), .MAX_OUT(2)) dut (
        .clk(clk), .reset(reset),
        .AXIS_PLEN_TDATA(AXIS_PLEN_TDATA), .AXIS_PLEN_TVALID(AXIS_PLEN_TVALID),
        .AXIS_PLEN_TREADY(AXIS_PLEN_TREADY),
        .AXIS_ADDR_TDATA(AXIS_ADDR_TDATA), .AXIS_ADDR_TVALID(AXIS_ADDR_TVALID),
        .AXIS_ADDR_TREADY(AXIS_ADDR_TREADY),
        .AXIS_DATA_TDATA(AXIS_DATA_TDATA), .AXIS_DATA_TLAST(AXIS_DATA_TLAST),
        .AXIS_DATA_TVALID(AXIS_DATA_TVALID), .AXIS_DATA_TREADY(AXIS_DATA_TREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWUSER(M_AXI_AWUSER),
        .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWID(M_AXI_AWID),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .PKT_COUNT(PKT_COUNT), .BRESP_ERR(BRESP_ERR), .LEN_ERR(LEN_ERR)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] plen; logic [95:0] ad; } ctl_t;
    typedef struct { logic [511:0] d; logic l; } beat_t;
    typedef struct { logic [63:0] addr; logic [31:0] user; logic [7:0] len; } aw_t;
    typedef struct { logic [511:0] d; logic [63:0] s; logic l; } w_t;

    ctl_t  ctl_q[$];
    beat_t data_q[$];
    aw_t   exp_aw[$];
    w_t    exp_w[$];

    int    cmp_cnt = 0;
    int    err_cnt = 0;
    int    cyc = 0;
    int    aw_seen = 0;
    int    w_seen = 0;
    int    b_pending = 0;
    int    b_credit = 1000000;
    int    pop_cyc = 0;
    int    b_cyc = 0;
    int    awv_rise_cyc = 0;
    bit    prev_awv = 1'b0;
    bit    ctl_fire;
    bit    dat_fire;
    bit    rnd_rdy = 1'b0;
    logic [1:0] bresp_val = 2'b00;

    // Hand-computed AWLEN for each length of the backpressure run.
    int unsigned plen_tab [20] = '{1, 63, 64, 65, 127, 128, 129, 200, 256, 300,
                                   1, 512, 513, 100, 192, 191, 10, 640, 70, 16384};
    int unsigned len_tab  [20] = '{0, 0, 0, 1, 1, 1, 2, 3, 3, 4,
                                   0, 7, 8, 1, 2, 2, 0, 9, 1, 255};

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: got an output with no expectation queued", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Control-stream driver (length and address pop together).
    initial begin
        ctl_t c;
        AXIS_PLEN_TVALID = 1'b0; AXIS_ADDR_TVALID = 1'b0;
        AXIS_PLEN_TDATA = 16'd0; AXIS_ADDR_TDATA = 96'd0;
        forever begin
            @(negedge clk);
            ctl_fire = AXIS_PLEN_TVALID && AXIS_PLEN_TREADY;
            @(posedge clk);
            #1;
            if (reset || ctl_fire) begin
                AXIS_PLEN_TVALID = 1'b0;
                AXIS_ADDR_TVALID = 1'b0;
            end
            if (!reset && !AXIS_PLEN_TVALID && ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                AXIS_PLEN_TDATA  = c.plen;
                AXIS_ADDR_TDATA  = c.ad;
                AXIS_PLEN_TVALID = 1'b1;
                AXIS_ADDR_TVALID = 1'b1;
            end
        end
    end

    // Data-stream driver.
    initial begin
        beat_t b;
        AXIS_DATA_TVALID = 1'b0; AXIS_DATA_TDATA = 512'd0; AXIS_DATA_TLAST = 1'b0;
        forever begin
            @(negedge clk);
            dat_fire = AXIS_DATA_TVALID && AXIS_DATA_TREADY;
            @(posedge clk);
            #1;
            if (reset || dat_fire) AXIS_DATA_TVALID = 1'b0;
            if (!reset && !AXIS_DATA_TVALID && data_q.size() > 0) begin
                b = data_q.pop_front();
                AXIS_DATA_TDATA  = b.d;
                AXIS_DATA_TLAST  = b.l;
                AXIS_DATA_TVALID = 1'b1;
            end
        end
    end

    // Slave side: ready generation and B responder.
    initial begin
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) begin
                M_AXI_AWREADY = 1'($urandom_range(0, 1));
                M_AXI_WREADY  = 1'($urandom_range(0, 1));
            end else begin
                M_AXI_AWREADY = 1'b1;
                M_AXI_WREADY  = 1'b1;
            end
            M_AXI_BVALID = !reset && (b_pending > 0) && (b_credit > 0);
            M_AXI_BRESP  = bresp_val;
        end
    end

    // Monitor / scoreboard: compares every presented AW and W against the queues.
    initial forever begin
        @(negedge clk);
        if (AXIS_PLEN_TVALID && AXIS_PLEN_TREADY) begin
            pop_cyc = cyc;
            check("addr_tready_with_plen", 512'(AXIS_ADDR_TREADY), 512'(1'b1));
        end
        if (M_AXI_AWVALID) begin
            if (!prev_awv) awv_rise_cyc = cyc;
            if (exp_aw.size() == 0) begin
                fail_now("aw_unexpected");
            end else begin
                check("awaddr", 512'(M_AXI_AWADDR), 512'(exp_aw[0].addr));
                check("awuser", 512'(M_AXI_AWUSER), 512'(exp_aw[0].user));
                check("awlen",  512'(M_AXI_AWLEN),  512'(exp_aw[0].len));
                if (M_AXI_AWREADY) begin
                    check("awsize",  512'(M_AXI_AWSIZE),  512'(3'd6));
                    check("awburst", 512'(M_AXI_AWBURST), 512'(2'b01));
                    check("awid",    512'(M_AXI_AWID),    512'(4'd0));
                    void'(exp_aw.pop_front());
                    b_pending++;
                    aw_seen++;
                end
            end
        end
        prev_awv = M_AXI_AWVALID;
        if (M_AXI_WVALID && M_AXI_WREADY) begin
            if (exp_w.size() == 0) begin
                fail_now("w_unexpected");
            end else begin
                check("wdata", M_AXI_WDATA, exp_w[0].d);
                check("wstrb", 512'(M_AXI_WSTRB), 512'(exp_w[0].s));
                check("wlast", 512'(M_AXI_WLAST), 512'(exp_w[0].l));
                check("data_tready", 512'(AXIS_DATA_TREADY), 512'(1'b1));
                void'(exp_w.pop_front());
                w_seen++;
            end
        end
        if (M_AXI_BVALID && M_AXI_BREADY) begin
            b_cyc = cyc;
            b_pending--;
            b_credit--;
        end
    end

    task automatic send_pkt(input logic [15:0] plen, input logic [63:0] addr,
                            input logic [31:0] user, input logic [7:0] awlen,
                            input int tag, input bit early_last);
        int          beats;
        int          rem;
        logic [63:0] ls;
        logic [511:0] d;
        logic [15:0] t16;
        logic [15:0] b16;
        beats = int'(awlen) + 1;
        rem   = int'(plen) % 64;
        if (plen == 16'd0)  ls = 64'd0;
        else if (rem == 0)  ls = '1;
        else                ls = (64'd1 << rem) - 64'd1;
        exp_aw.push_back('{addr: addr, user: user, len: awlen});
        t16 = 16'(tag);
        for (int b = 0; b < beats; b++) begin
            b16 = 16'(b);
            d = {16{t16, b16}};
            exp_w.push_back('{d: d, s: (b == beats - 1) ? ls : '1, l: (b == beats - 1)});
            data_q.push_back('{d: d, l: early_last ? (b == 0) : (b == beats - 1)});
        end
        ctl_q.push_back('{plen: plen, ad: {user, addr}});
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((ctl_q.size() != 0 || data_q.size() != 0 || exp_aw.size() != 0 ||
                exp_w.size() != 0 || b_pending != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_drain_in_time"}, 512'(n < limit), 512'(1'b1));
    endtask

    // Asserts reset for one edge; call just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        ctl_q.delete(); data_q.delete(); exp_aw.delete(); exp_w.delete();
        b_pending = 0;
        @(negedge clk);
        check("rst_awvalid",   512'(M_AXI_AWVALID),    512'(1'b0));
        check("rst_wvalid",    512'(M_AXI_WVALID),     512'(1'b0));
        check("rst_plen_rdy",  512'(AXIS_PLEN_TREADY), 512'(1'b0));
        check("rst_addr_rdy",  512'(AXIS_ADDR_TREADY), 512'(1'b0));
        check("rst_data_rdy",  512'(AXIS_DATA_TREADY), 512'(1'b0));
        check("rst_bready",    512'(M_AXI_BREADY),     512'(1'b0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_awvalid",  512'(M_AXI_AWVALID), 512'(1'b0));
        check("post_rst_wvalid",   512'(M_AXI_WVALID),  512'(1'b0));
        check("post_rst_pkt",      512'(PKT_COUNT),     512'(32'd0));
        check("post_rst_bresp_err", 512'(BRESP_ERR),    512'(1'b0));
        check("post_rst_len_err",  512'(LEN_ERR),       512'(1'b0));
        check("post_rst_bready",   512'(M_AXI_BREADY),  512'(1'b1));
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1;
        @(posedge clk);
        #2;
        do_reset();

        // Single-beat packet.
        send_pkt(16'd64, 64'h1000, 32'hA5, 8'd0, 1, 1'b0);
        wait_idle("t1", 200);
        check("t1_pkt_count", 512'(PKT_COUNT), 512'(32'd1));
        check("t1_len_err",   512'(LEN_ERR),   512'(1'b0));

        // Three beats with a two-byte final strobe.
        send_pkt(16'd130, 64'h2000, 32'h5A5A, 8'd2, 2, 1'b0);
        wait_idle("t2", 200);
        check("t2_pkt_count", 512'(PKT_COUNT), 512'(32'd2));
        check("t2_len_err",   512'(LEN_ERR),   512'(1'b0));

        // Outstanding limit: responses withheld, third packet must stall.
        b_credit = 0;
        base = aw_seen;
        for (int i = 0; i < 3; i++) send_pkt(16'd64, 64'h3000 + 64'(i * 64), 32'(i), 8'd0, 10 + i, 1'b0);
        n = 0;
        while (aw_seen < base + 2 && n < 200) begin @(posedge clk); n++; end
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t3_aw_count_stalled", 512'(aw_seen - base), 512'(2));
        check("t3_awvalid_stalled",  512'(M_AXI_AWVALID),   512'(1'b0));
        check("t3_plen_rdy_stalled", 512'(AXIS_PLEN_TREADY), 512'(1'b0));
        @(posedge clk);
        #2;
        b_credit = 1;
        n = 0;
        while (aw_seen < base + 3 && n < 200) begin @(posedge clk); n++; end
        @(negedge clk);
        check("t3_third_aw",  512'(aw_seen - base),          512'(3));
        check("t3_b_to_pop",  512'(pop_cyc - b_cyc),         512'(1));
        check("t3_pop_to_aw", 512'(awv_rise_cyc - pop_cyc),  512'(1));
        b_credit = 1000000;
        wait_idle("t3", 300);
        check("t3_pkt_count", 512'(PKT_COUNT), 512'(32'd5));

        // Twenty packets under random AW/W backpressure.
        @(posedge clk);
        #2;
        do_reset();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++)
            send_pkt(16'(plen_tab[i]), 64'h10000 + 64'(i * 4096), 32'hC000 + 32'(i),
                     8'(len_tab[i]), 100 + i, 1'b0);
        wait_idle("t4", 5000);
        rnd_rdy = 1'b0;
        check("t4_pkt_count", 512'(PKT_COUNT), 512'(32'd20));
        check("t4_len_err",   512'(LEN_ERR),   512'(1'b0));

        // TLAST arriving early on a two-beat packet.
        @(posedge clk);
        #2;
        do_reset();
        send_pkt(16'd128, 64'h4000, 32'h77, 8'd1, 30, 1'b1);
        wait_idle("t5a", 300);
        check("t5a_len_err",   512'(LEN_ERR),   512'(1'b1));
        check("t5a_pkt_count", 512'(PKT_COUNT), 512'(32'd1));

        // Zero-length packet answered with SLVERR.
        @(posedge clk);
        #2;
        do_reset();
        bresp_val = 2'b10;
        send_pkt(16'd0, 64'h5000, 32'h88, 8'd0, 31, 1'b0);
        wait_idle("t5b", 300);
        bresp_val = 2'b00;
        check("t5b_len_err",   512'(LEN_ERR),   512'(1'b1));
        check("t5b_bresp_err", 512'(BRESP_ERR), 512'(1'b1));
        check("t5b_pkt_count", 512'(PKT_COUNT), 512'(32'd0));

        // Reset during beat 1 of a four-beat burst, then a normal packet.
        @(posedge clk);
        #2;
        do_reset();
        base = w_seen;
        send_pkt(16'd256, 64'h6000, 32'h99, 8'd3, 40, 1'b0);
        n = 0;
        while (w_seen != base + 1 && n < 300) begin @(posedge clk); #2; n++; end
        check("t6_reached_beat1", 512'(n < 300), 512'(1'b1));
        do_reset();
        send_pkt(16'd100, 64'h7000, 32'hAA, 8'd1, 41, 1'b0);
        wait_idle("t6", 300);
        check("t6_pkt_count", 512'(PKT_COUNT), 512'(32'd1));
        check("t6_len_err",   512'(LEN_ERR),   512'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
